// File: rtl/pc_unit.sv
// Program counter unit: sequential fetch, redirects, traps and a circular
// return-address stack (RAS) for call/return prediction.
module pc_unit #(
  parameter int unsigned     BITS         = 64,
  parameter logic [BITS-1:0] RESET_VECTOR = '0,
  parameter logic [BITS-1:0] TRAP_VECTOR  = '0,
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap,
  input  logic            redirect_en,
  input  logic [BITS-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  output logic [BITS-1:0] pc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(RAS_DEPTH);
  localparam logic [BITS-1:0] IncC = BITS'(INSTR_BYTES);

  logic [BITS-1:0] pc_q, pc_d;
  logic            valid_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  // sp_q is the next write slot; the top of stack is sp_q - 1.
  logic [PW-1:0]   sp_q, sp_d;
  logic            uflow_q, uflow_d;
  logic [BITS-1:0] ras_q [RAS_DEPTH];

  logic            push_en;
  logic [PW-1:0]   push_idx;
  logic [BITS-1:0] seq_pc;
  logic [PW-1:0]   top_idx;

  assign seq_pc  = pc_q + IncC;
  assign top_idx = sp_q - PW'(1);

  // Next-state selection: trap > stall > ret > call > redirect > sequential.
  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    sp_d     = sp_q;
    uflow_d  = 1'b0;
    push_en  = 1'b0;
    push_idx = sp_q;
    if (trap) begin
      pc_d  = TRAP_VECTOR;
      cnt_d = '0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (ret && (cnt_q != '0)) begin
      pc_d = ras_q[top_idx];
      if (call) begin
        // Call+ret: the popped slot is reused for the new return address.
        push_en  = 1'b1;
        push_idx = top_idx;
      end else begin
        sp_d  = top_idx;
        cnt_d = cnt_q - CW'(1);
      end
    end else if (ret) begin
      uflow_d = 1'b1;
      pc_d    = redirect_target;
      if (call) begin
        push_en = 1'b1;
        sp_d    = sp_q + PW'(1);
        cnt_d   = CW'(1);
      end
    end else if (call) begin
      pc_d    = redirect_target;
      push_en = 1'b1;
      sp_d    = sp_q + PW'(1);
      // When full the oldest entry is overwritten and the count saturates.
      if (cnt_q != DepthC) cnt_d = cnt_q + CW'(1);
    end else if (redirect_en) begin
      pc_d = redirect_target;
    end else begin
      pc_d = seq_pc;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      sp_q    <= '0;
      uflow_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      uflow_q <= uflow_d;
    end
  end

  // RAS storage; contents are not reset, only the count is.
  always_ff @(posedge clk) begin
    if (!rst && push_en) ras_q[push_idx] <= seq_pc;
  end

  // Outputs.
  always_comb begin
    pc            = pc_q;
    pc_valid      = valid_q;
    ras_empty     = (cnt_q == '0);
    ras_full      = (cnt_q == DepthC);
    ras_underflow = uflow_q;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with hand-computed expected values.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, trap, redirect_en, call, ret;
  logic [63:0] redirect_target;
  logic [63:0] pc;
  logic        pc_valid, ras_empty, ras_full, ras_underflow;

  int total = 0;
  int bad   = 0;

  pc_unit #(
    .BITS        (64),
    .RESET_VECTOR(64'h1000),
    .TRAP_VECTOR (64'h2000),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .trap           (trap),
    .redirect_en    (redirect_en),
    .redirect_target(redirect_target),
    .call           (call),
    .ret            (ret),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full),
    .ras_underflow  (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; trap = 0; redirect_en = 0; call = 0; ret = 0;
  endtask

  initial begin
    rst = 1; idle(); redirect_target = '0;
    #1;
    step(); step();
    check("rst_pc", pc, 64'h1000);
    check("rst_valid", pc_valid, 0);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_uflow", ras_underflow, 0);

    // Sequential fetch after reset release.
    rst = 0;
    step(); check("seq1_pc", pc, 64'h1004); check("seq1_valid", pc_valid, 1);
    step(); check("seq2_pc", pc, 64'h1008);
    step(); check("seq3_pc", pc, 64'h100C);

    // Call at 0x1008 to 0x3000, then return to 0x100C.
    rst = 1; step(); rst = 0; step(); step();
    check("pre_call_pc", pc, 64'h1008);
    call = 1; redirect_target = 64'h3000; step();
    check("call_pc", pc, 64'h3000); check("call_empty", ras_empty, 0);
    call = 0; ret = 1; step();
    check("ret_pc", pc, 64'h100C); check("ret_empty", ras_empty, 1);
    ret = 0;

    // Five calls from 0x1000 push 0x1004,0x4004,0x5004,0x6004,0x7004;
    // the fifth overwrites 0x1004.
    rst = 1; step(); rst = 0;
    check("deep_start", pc, 64'h1000);
    call = 1;
    for (int i = 0; i < 5; i++) begin
      redirect_target = 64'h4000 + 64'(i) * 64'h1000;
      step();
      check("deep_call_pc", pc, redirect_target);
      if (i == 3) check("full_after_4", ras_full, 1);
    end
    check("full_after_5", ras_full, 1);
    call = 0; ret = 1; redirect_target = 64'hDEAD0;
    step(); check("pop1", pc, 64'h7004); check("pop1_full", ras_full, 0);
    step(); check("pop2", pc, 64'h6004);
    step(); check("pop3", pc, 64'h5004);
    step(); check("pop4", pc, 64'h4004); check("pop4_empty", ras_empty, 1);

    // Return on empty RAS goes to redirect_target and pulses underflow.
    redirect_target = 64'h9000; step();
    check("uf_pc", pc, 64'h9000); check("uf_pulse", ras_underflow, 1);
    check("uf_empty", ras_empty, 1);
    ret = 0; step();
    check("uf_clear", ras_underflow, 0); check("uf_seq", pc, 64'h9004);

    // Trap wins over stall and call, and flushes the RAS.
    call = 1; redirect_target = 64'hA000; step();
    check("pretrap_cnt", ras_empty, 0);
    trap = 1; stall = 1; call = 1; redirect_target = 64'hB000; step();
    check("trap_pc", pc, 64'h2000); check("trap_empty", ras_empty, 1);
    idle();

    // Call+ret together on non-empty RAS: pop 0x2004, replace top with 0xB004.
    call = 1; redirect_target = 64'hB000; step();
    check("cr_call", pc, 64'hB000);
    ret = 1; redirect_target = 64'hC000; step();
    check("cr_pc", pc, 64'h2004); check("cr_cnt", ras_empty, 0);
    call = 0; step();
    check("cr_ret", pc, 64'hB004); check("cr_empty", ras_empty, 1);
    ret = 0;

    // Call+ret on empty RAS: acts as call, pulses underflow.
    call = 1; ret = 1; redirect_target = 64'hC000; step();
    check("cre_pc", pc, 64'hC000); check("cre_uf", ras_underflow, 1);
    check("cre_cnt", ras_empty, 0);
    call = 0; step();
    check("cre_ret", pc, 64'hB008); check("cre_uf_clr", ras_underflow, 0);
    ret = 0;

    // Plain redirect, then wrap from the top of the address space.
    redirect_en = 1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC; step();
    check("redir_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    redirect_en = 0; step();
    check("wrap_pc", pc, 64'h0);

    // Stall holds pc and drops the call.
    stall = 1; call = 1; redirect_target = 64'h5550;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_pc", pc, 64'h0);
    end
    check("stall_empty", ras_empty, 1);

    // Build count 2, then reset while stalled.
    stall = 0; call = 1; redirect_target = 64'h100; step();
    redirect_target = 64'h200; step();
    check("cnt2_pc", pc, 64'h200);
    call = 0; stall = 1; step();
    check("cnt2_hold", pc, 64'h200); check("cnt2_nonempty", ras_empty, 0);
    rst = 1; step();
    check("midrst_pc", pc, 64'h1000); check("midrst_empty", ras_empty, 1);
    check("midrst_valid", pc_valid, 0);
    rst = 0; stall = 0; step();
    check("post_rst_pc", pc, 64'h1004); check("post_rst_valid", pc_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
